// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM states and default latencies for the multiply/divide unit
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_core.sv
// rtl/md_core.sv - combinational multiply/divide datapath
// Result packs {HI, LO}: product halves for multiplies, {remainder, quotient} for divides.
module md_core
  import md_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_zero
);

  logic        w_mul_signed;
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  always_comb begin
    w_mul_signed = (i_op == MD_MULT);
    w_div_signed = (i_op == MD_DIV);

    // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
    w_ma   = w_mul_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
    w_mb   = w_mul_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
    w_prod = w_ma * w_mb;

    // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps to 0x80000000 with no trap.
    w_a_neg   = w_div_signed & i_a[31];
    w_b_neg   = w_div_signed & i_b[31];
    w_a_mag   = w_a_neg ? (~i_a + 32'd1) : i_a;
    w_b_mag   = w_b_neg ? (~i_b + 32'd1) : i_b;
    w_divisor = (i_b == 32'd0) ? 32'd1 : w_b_mag;
    w_uq      = w_a_mag / w_divisor;
    w_ur      = w_a_mag % w_divisor;
    w_q       = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
    w_r       = w_a_neg ? (~w_ur + 32'd1) : w_ur;

    o_div_zero = 1'b0;
    o_result   = 64'd0;
    case (i_op)
      MD_MULT, MD_MULTU: o_result = w_prod;
      MD_DIV, MD_DIVU: begin
        o_result   = {w_r, w_q};
        o_div_zero = (i_b == 32'd0);
      end
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with architectural HI/LO
// Result is computed at issue and held in pending registers until the latency counter expires.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_WIDTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_WIDTH-1:0] L_MULT_LOAD = CNT_WIDTH'(MULT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] L_DIV_LOAD  = CNT_WIDTH'(DIV_CYCLES);
  localparam logic [CNT_WIDTH-1:0] L_ONE       = CNT_WIDTH'(1);

  md_state_e            r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [63:0]          r_pend;
  logic                 r_pend_skip;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;

  md_state_e            w_state_nx;
  logic [CNT_WIDTH-1:0] w_cnt_nx;
  logic [63:0]          w_pend_nx;
  logic                 w_skip_nx;
  logic [31:0]          w_hi_nx;
  logic [31:0]          w_lo_nx;
  logic [63:0]          w_result;
  logic                 w_div_zero;

  md_core u_core (
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_pend_skip <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_pend      <= w_pend_nx;
      r_pend_skip <= w_skip_nx;
      r_hi        <= w_hi_nx;
      r_lo        <= w_lo_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend;
    w_skip_nx  = r_pend_skip;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              w_state_nx = S_BUSY;
              w_cnt_nx   = L_MULT_LOAD;
              w_pend_nx  = w_result;
              w_skip_nx  = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              w_state_nx = S_BUSY;
              w_cnt_nx   = L_DIV_LOAD;
              w_pend_nx  = w_result;
              w_skip_nx  = w_div_zero;
            end
            MD_MTHI: w_hi_nx = a;
            MD_MTLO: w_lo_nx = a;
            default: w_state_nx = S_IDLE;
          endcase
        end
      end
      S_BUSY: begin
        // Requests arriving while busy are dropped; the hazard unit never issues them.
        w_cnt_nx = r_cnt - L_ONE;
        if (r_cnt == L_ONE) begin
          w_state_nx = S_IDLE;
          if (!r_pend_skip) begin
            w_hi_nx = r_pend[63:32];
            w_lo_nx = r_pend[31:0];
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  vec_t vecs[14];
  vec_t sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic wait_done(input string name);
    int   cyc;
    vec_t e;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
      check({name, "_hi"}, hi, e.hi);
      check({name, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd5, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFD, 0};
    vecs[4]  = '{3'd6, 32'h00005678, 32'h0,        32'h00001234, 32'h00005678, 0};
    vecs[5]  = '{3'd4, 32'h00012345, 32'h0,        32'h00001234, 32'h00005678, 10};
    vecs[6]  = '{3'd3, 32'h00000005, 32'h0,        32'h00001234, 32'h00005678, 10};
    vecs[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[11] = '{3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5};
    vecs[12] = '{3'd0, 32'hAAAA5555, 32'h00000003, 32'h00000001, 32'h00000000, 0};
    vecs[13] = '{3'd7, 32'hAAAA5555, 32'h00000003, 32'h00000001, 32'h00000000, 0};

    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i]);
      wait_done($sformatf("vec%0d", i));
    end

    // MULT 3x4, MTLO pulsed while busy must be dropped
    v = '{3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5};
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    sb.push_back(v);
    @(negedge clk);
    op = 3'd6; a = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    check("mtlo_ignored_lo_during_busy", lo, 32'd0);
    begin
      int   cyc;
      vec_t e;
      cyc = 2;
      while (busy === 1'b1 && cyc < 40) begin
        cyc++;
        @(negedge clk);
      end
      cyc = cyc - 1;
      e = sb.pop_front();
      check("seqA_busy_cycles", 32'(cyc), 32'(e.cyc));
      check("seqA_hi", hi, e.hi);
      check("seqA_lo", lo, e.lo);
    end

    // DIVU 12/5 issued in the cycle busy falls
    v = '{3'd4, 32'd12, 32'd5, 32'd2, 32'd2, 10};
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_done("b2b_divu");

    // Reset in the third busy cycle of a DIV aborts it
    v = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10};
    issue(v);
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_commit_busy", {31'd0, busy}, 32'd0);
    check("abort_no_commit_hi", hi, 32'd0);
    check("abort_no_commit_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
